// File: rtl/clause_queue_pkg.sv
// Shared clause payload type and clause-queue sizing defaults.
package clause_queue_pkg;

    localparam int unsigned CLQ_DEPTH     = 16;
    localparam int unsigned CLQ_AF_MARGIN = 2;

    localparam int unsigned CLA_ID_W  = 16;
    localparam int unsigned CLA_LBD_W = 8;

    typedef struct packed {
        logic [CLA_ID_W-1:0]  id;
        logic [CLA_LBD_W-1:0] lbd;
        logic                 learnt;
    } cla_t;

endpackage

// File: rtl/clause_queue_if.sv
// Switch-to-engine clause queue bus; slave is the queue, master is producer/engine side.
interface clause_queue_if
    import clause_queue_pkg::*;
#(
    parameter int unsigned DEPTH = CLQ_DEPTH
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    cla_t             sw2clq;
    logic             sw2clq_valid;
    logic             clq_flush;
    cla_t             clq2eng;
    logic             clq2eng_valid;
    logic             eng2clq_ready;
    logic             clq_full;
    logic             clq_almost_full;
    logic [CNT_W-1:0] clq_count;
    logic             clq_overflow;

    modport master (
        output sw2clq, sw2clq_valid, clq_flush, eng2clq_ready,
        input  clq2eng, clq2eng_valid, clq_full, clq_almost_full, clq_count, clq_overflow
    );

    modport slave (
        input  sw2clq, sw2clq_valid, clq_flush, eng2clq_ready,
        output clq2eng, clq2eng_valid, clq_full, clq_almost_full, clq_count, clq_overflow
    );

endinterface

// File: rtl/clause_queue_mem.sv
// Clause storage: one synchronous write port, one asynchronous read port; not reset.
module clause_queue_mem
    import clause_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = CLQ_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  cla_t          wdata_i,
    input  logic [AW-1:0] raddr_i,
    output cla_t          rdata_o
);

    cla_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/clause_queue.sv
// Show-ahead clause FIFO between switch and engine with full/almost-full flags and sticky overflow.
module clause_queue
    import clause_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = CLQ_DEPTH,
    parameter int unsigned AF_MARGIN = CLQ_AF_MARGIN
) (
    input  logic           clk,
    input  logic           rst_n,
    clause_queue_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, full_q, af_q;
    logic             pop_c, push_ok_c, drop_c, we_c;
    cla_t             head_c;

    assign pop_c     = valid_q && bus.eng2clq_ready;
    assign push_ok_c = bus.sw2clq_valid && (!full_q || pop_c);
    assign drop_c    = bus.sw2clq_valid && full_q && !pop_c;

    // Flush wins over push/pop but leaves the overflow record intact.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        we_c  = 1'b0;
        if (bus.clq_flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (drop_c) ovf_d = 1'b1;
            if (push_ok_c) begin
                we_c = 1'b1;
                wr_d = wr_q + PTR_W'(1);
            end
            if (pop_c) rd_d = rd_q + PTR_W'(1);
            if (push_ok_c && !pop_c) cnt_d = cnt_q + CNT_W'(1);
            else if (pop_c && !push_ok_c) cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Flags are registered images of the next count, so they track clq_count exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            valid_q <= (cnt_d != '0);
            full_q  <= (cnt_d == CNT_W'(DEPTH));
            af_q    <= (cnt_d >= CNT_W'(DEPTH - AF_MARGIN));
        end
    end

    clause_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (we_c),
        .waddr_i (wr_q),
        .wdata_i (bus.sw2clq),
        .raddr_i (rd_q),
        .rdata_o (head_c)
    );

    assign bus.clq2eng         = head_c;
    assign bus.clq2eng_valid   = valid_q;
    assign bus.clq_full        = full_q;
    assign bus.clq_almost_full = af_q;
    assign bus.clq_count       = cnt_q;
    assign bus.clq_overflow    = ovf_q;

endmodule

// File: tb/tb_clause_queue.sv
// Directed and random checks of clause_queue against a queue-based reference model.
module tb_clause_queue;
    import clause_queue_pkg::*;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned AF_MARGIN = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    clause_queue_if #(.DEPTH(DEPTH)) bus ();

    clause_queue #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    cla_t mq[$];
    bit   movf = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic cla_t mk(input int i);
        cla_t c;
        c.id     = 16'(i);
        c.lbd    = 8'(i * 3 + 1);
        c.learnt = i[0];
        return c;
    endfunction

    // Reference model: a plain queue updated with the rules of the queue's contract.
    always @(posedge clk) begin
        bit pop, full;
        if (!rst_n) begin
            mq.delete();
            movf = 1'b0;
        end else if (bus.clq_flush) begin
            mq.delete();
        end else begin
            pop  = (mq.size() > 0) && bus.eng2clq_ready;
            full = (mq.size() == DEPTH);
            if (bus.sw2clq_valid && full && !pop) movf = 1'b1;
            if (pop) void'(mq.pop_front());
            if (bus.sw2clq_valid && (!full || pop)) mq.push_back(bus.sw2clq);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", 64'(bus.clq2eng_valid), 64'(mq.size() > 0));
            chk("m_count", 64'(bus.clq_count), 64'(mq.size()));
            chk("m_full", 64'(bus.clq_full), 64'(mq.size() == DEPTH));
            chk("m_afull", 64'(bus.clq_almost_full), 64'((DEPTH - mq.size()) <= AF_MARGIN));
            chk("m_ovf", 64'(bus.clq_overflow), 64'(movf));
            if (mq.size() > 0) chk("m_head", 64'(bus.clq2eng), 64'(mq[0]));
        end
    end

    // Drive one cycle of inputs at a falling edge, return at the next falling edge.
    task automatic step(input bit v, input cla_t d, input bit rdy, input bit fl);
        bus.sw2clq_valid  = v;
        bus.sw2clq        = d;
        bus.eng2clq_ready = rdy;
        bus.clq_flush     = fl;
        @(negedge clk);
    endtask

    initial begin
        cla_t x, y;
        x = mk(99);
        y = mk(77);
        rst_n = 1'b0;
        @(negedge clk);
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        chk("rst_count", 64'(bus.clq_count), 64'd0);
        chk("rst_valid", 64'(bus.clq2eng_valid), 64'd0);
        chk("rst_full", 64'(bus.clq_full), 64'd0);
        chk("rst_afull", 64'(bus.clq_almost_full), 64'd0);
        chk("rst_ovf", 64'(bus.clq_overflow), 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        step(1, mk(200), 0, 0);
        chk("a_valid", 64'(bus.clq2eng_valid), 64'd1);
        chk("a_head", 64'(bus.clq2eng), 64'(mk(200)));
        step(0, '0, 1, 0);
        chk("a_pop_count", 64'(bus.clq_count), 64'd0);

        for (int i = 0; i < 16; i++) begin
            step(1, mk(i), 0, 0);
            chk("fill_count", 64'(bus.clq_count), 64'(i + 1));
            chk("fill_afull", 64'(bus.clq_almost_full), 64'(i + 1 >= 14));
            chk("fill_full", 64'(bus.clq_full), 64'(i + 1 == 16));
        end

        step(1, y, 1, 0);
        chk("pp_count", 64'(bus.clq_count), 64'd16);
        chk("pp_ovf", 64'(bus.clq_overflow), 64'd0);

        step(1, x, 0, 0);
        chk("ovf_count", 64'(bus.clq_count), 64'd16);
        chk("ovf_set", 64'(bus.clq_overflow), 64'd1);

        for (int k = 1; k < 16; k++) begin
            chk("drain_head", 64'(bus.clq2eng), 64'(mk(k)));
            step(0, '0, 1, 0);
        end
        chk("drain_last", 64'(bus.clq2eng), 64'(y));
        step(0, '0, 1, 0);
        chk("drain_empty", 64'(bus.clq2eng_valid), 64'd0);
        chk("drain_ovf", 64'(bus.clq_overflow), 64'd1);
        step(0, '0, 0, 1);
        chk("flush_ovf_kept", 64'(bus.clq_overflow), 64'd1);

        for (int i = 0; i < 5; i++) step(1, mk(40 + i), 0, 0);
        chk("f5_count", 64'(bus.clq_count), 64'd5);
        step(1, mk(50), 1, 1);
        chk("fl_count", 64'(bus.clq_count), 64'd0);
        chk("fl_valid", 64'(bus.clq2eng_valid), 64'd0);
        chk("fl_ovf", 64'(bus.clq_overflow), 64'd1);
        step(0, '0, 0, 0);
        chk("fl_lost", 64'(bus.clq_count), 64'd0);

        step(1, mk(60), 1, 0);
        chk("ep_count", 64'(bus.clq_count), 64'd1);
        chk("ep_head", 64'(bus.clq2eng), 64'(mk(60)));

        step(1, mk(61), 0, 0);
        rst_n = 1'b0;
        step(0, '0, 0, 0);
        rst_n = 1'b1;
        chk("mrst_count", 64'(bus.clq_count), 64'd0);
        chk("mrst_ovf", 64'(bus.clq_overflow), 64'd0);
        chk("mrst_valid", 64'(bus.clq2eng_valid), 64'd0);

        for (int i = 0; i < 10000; i++) begin
            int rp;
            rp = ((i / 500) % 2 == 0) ? 30 : 75;
            step(bit'($urandom_range(0, 99) < 65), mk(int'($urandom_range(0, 65535))),
                 bit'($urandom_range(0, 99) < rp), bit'($urandom_range(0, 99) < 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
